// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch controller states; at most one memory request is ever in flight.
    typedef enum logic [1:0] {
        ST_REQ     = 2'b00,  // presenting a request at pcF
        ST_WAIT    = 2'b01,  // request accepted, waiting for its response
        ST_DISCARD = 2'b10,  // redirected while a response is still owed; drop it
        ST_HOLD    = 2'b11   // response captured while decode was stalled
    } fetch_state_t;

    // Instruction loaded into IF/ID for a bubble (all zeros).
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Default fetch address after reset.
    localparam logic [31:0] RESETPC_DEFAULT = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_stage_ctrl_ifid.sv
// IF/ID pipeline register: load a fetched instruction, hold on stall,
// invalidate on flush (flush wins over stall), otherwise insert a bubble.
module ifid_register
    import fetch_pkg::*;
#(
    parameter int PCWIDTH    = 32,
    parameter int INSTRWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [INSTRWIDTH-1:0] next_instr,
    input  logic [PCWIDTH-1:0]    next_pc,
    input  logic [PCWIDTH-1:0]    next_pc_plus4,
    output logic [INSTRWIDTH-1:0] instr,
    output logic [PCWIDTH-1:0]    pc,
    output logic [PCWIDTH-1:0]    pc_plus4,
    output logic                  valid
);

    localparam logic [INSTRWIDTH-1:0] NOP_INSTR = INSTRWIDTH'(NOP);
    localparam logic [PCWIDTH-1:0]    PC_ZERO   = {PCWIDTH{1'b0}};

    logic [INSTRWIDTH-1:0] instr_r;
    logic [PCWIDTH-1:0]    pc_r;
    logic [PCWIDTH-1:0]    pc_plus4_r;
    logic                  valid_r;

    // Pipeline register update with flush > stall > load > bubble priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r    <= NOP_INSTR;
            pc_r       <= PC_ZERO;
            pc_plus4_r <= PC_ZERO;
            valid_r    <= 1'b0;
        end else if (flush) begin
            instr_r    <= NOP_INSTR;
            valid_r    <= 1'b0;
        end else if (stall) begin
            instr_r    <= instr_r;
            pc_r       <= pc_r;
            pc_plus4_r <= pc_plus4_r;
            valid_r    <= valid_r;
        end else if (load) begin
            instr_r    <= next_instr;
            pc_r       <= next_pc;
            pc_plus4_r <= next_pc_plus4;
            valid_r    <= 1'b1;
        end else begin
            // Nothing delivered this cycle: bubble, program counters kept.
            instr_r    <= NOP_INSTR;
            valid_r    <= 1'b0;
        end
    end

    assign instr    = instr_r;
    assign pc       = pc_r;
    assign pc_plus4 = pc_plus4_r;
    assign valid    = valid_r;

endmodule : ifid_register

// File: rtl/fetch_stage_ctrl.sv
// Instruction fetch controller: owns pcF and the request/response FSM,
// keeps one memory request outstanding, parks a response that arrives while
// decode is stalled, and drops responses made stale by a branch redirect.
module fetch_stage_ctrl
    import fetch_pkg::*;
#(
    parameter int                  PCWIDTH    = 32,
    parameter int                  INSTRWIDTH = 32,
    parameter logic [PCWIDTH-1:0]  RESETPC    = PCWIDTH'(RESETPC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stallF,
    input  logic                  stallD,
    input  logic                  flushD,
    input  logic                  takeBranchE,
    input  logic [PCWIDTH-1:0]    branchTargetE,
    output logic                  imemReqValid,
    input  logic                  imemReqReady,
    output logic [PCWIDTH-1:0]    imemReqAddress,
    input  logic                  imemRespValid,
    input  logic [INSTRWIDTH-1:0] imemRespData,
    output logic [INSTRWIDTH-1:0] instrD,
    output logic [PCWIDTH-1:0]    pcD,
    output logic [PCWIDTH-1:0]    pcPlus4D,
    output logic                  validD
);

    localparam logic [PCWIDTH-1:0]    PC_STEP   = PCWIDTH'(32'd4);
    localparam logic [INSTRWIDTH-1:0] NOP_INSTR = INSTRWIDTH'(NOP);

    fetch_state_t          state_r;
    logic [PCWIDTH-1:0]    pc_r;
    logic                  req_valid_r;
    logic [INSTRWIDTH-1:0] buf_instr_r;

    logic [PCWIDTH-1:0]    pc_plus4_s;
    logic [PCWIDTH-1:0]    target_aligned_s;
    logic                  accept_s;
    logic                  deliver_s;
    logic [INSTRWIDTH-1:0] deliver_instr_s;

    // Sequential PC increment; wraps naturally at 2^PCWIDTH.
    assign pc_plus4_s       = pc_r + PC_STEP;
    // Redirect targets are always word aligned.
    assign target_aligned_s = {branchTargetE[PCWIDTH-1:2], 2'b00};
    // Request handshake completes on this edge.
    assign accept_s         = (state_r == ST_REQ) && req_valid_r && imemReqReady;

    // Decide whether an instruction enters IF/ID this cycle, and from where.
    always_comb begin
        deliver_s       = 1'b0;
        deliver_instr_s = imemRespData;
        if (takeBranchE) begin
            // A redirect makes whatever is in flight or parked stale.
            deliver_s       = 1'b0;
            deliver_instr_s = imemRespData;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    deliver_s       = imemRespValid && !stallD && !stallF;
                    deliver_instr_s = imemRespData;
                end
                ST_HOLD: begin
                    deliver_s       = !stallD;
                    deliver_instr_s = buf_instr_r;
                end
                default: begin
                    deliver_s       = 1'b0;
                    deliver_instr_s = imemRespData;
                end
            endcase
        end
    end

    // Fetch FSM with registered request-valid, PC and parked-instruction buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_REQ;
            pc_r        <= RESETPC;
            req_valid_r <= 1'b0;
            buf_instr_r <= NOP_INSTR;
        end else if (takeBranchE) begin
            // Redirect wins over stallF and empties the parked buffer.
            pc_r        <= target_aligned_s;
            buf_instr_r <= NOP_INSTR;
            case (state_r)
                ST_REQ: begin
                    if (accept_s) begin
                        // Old address was just accepted; its response is owed.
                        state_r     <= ST_DISCARD;
                        req_valid_r <= 1'b0;
                    end else begin
                        // Not yet accepted, so the address may simply change.
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end
                end
                ST_WAIT, ST_DISCARD: begin
                    if (imemRespValid) begin
                        // Outstanding response arrives now and is dropped.
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_DISCARD;
                        req_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    state_r     <= ST_REQ;
                    req_valid_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_REQ;
                    req_valid_r <= 1'b1;
                end
            endcase
        end else begin
            case (state_r)
                ST_REQ: begin
                    // Responses seen here belong to nothing and are ignored.
                    if (accept_s) begin
                        state_r     <= ST_WAIT;
                        req_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imemRespValid && deliver_s) begin
                        pc_r        <= pc_plus4_s;
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end else if (imemRespValid) begin
                        // Decode or fetch stalled: park the instruction.
                        buf_instr_r <= imemRespData;
                        state_r     <= ST_HOLD;
                        req_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_WAIT;
                        req_valid_r <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (imemRespValid) begin
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_DISCARD;
                        req_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (deliver_s) begin
                        pc_r        <= pc_plus4_s;
                        buf_instr_r <= NOP_INSTR;
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_HOLD;
                        req_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_REQ;
                    req_valid_r <= 1'b1;
                end
            endcase
        end
    end

    assign imemReqValid   = req_valid_r;
    assign imemReqAddress = pc_r;

    ifid_register #(
        .PCWIDTH    (PCWIDTH),
        .INSTRWIDTH (INSTRWIDTH)
    ) u_ifid (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (deliver_s),
        .stall         (stallD),
        .flush         (flushD),
        .next_instr    (deliver_instr_s),
        .next_pc       (pc_r),
        .next_pc_plus4 (pc_plus4_s),
        .instr         (instrD),
        .pc            (pcD),
        .pc_plus4      (pcPlus4D),
        .valid         (validD)
    );

endmodule : fetch_stage_ctrl

// File: tb/tb_fetch_stage_ctrl.sv
// Directed, table-driven bench for fetch_stage_ctrl.
module tb_fetch_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stallF, stallD, flushD, takeBranchE;
    logic [31:0] branchTargetE;
    logic        imemReqValid, imemReqReady, imemRespValid;
    logic [31:0] imemReqAddress, imemRespData;
    logic [31:0] instrD, pcD, pcPlus4D;
    logic        validD;

    // Second instance exercising the PC wrap from a high reset address.
    logic        w_rst_n;
    logic        w_stallF, w_stallD, w_flushD, w_takeBranchE;
    logic [31:0] w_branchTargetE;
    logic        w_imemReqValid, w_imemReqReady, w_imemRespValid;
    logic [31:0] w_imemReqAddress, w_imemRespData;
    logic [31:0] w_instrD, w_pcD, w_pcPlus4D;
    logic        w_validD;

    int checks = 0;
    int errors = 0;

    fetch_stage_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .takeBranchE(takeBranchE), .branchTargetE(branchTargetE),
        .imemReqValid(imemReqValid), .imemReqReady(imemReqReady),
        .imemReqAddress(imemReqAddress), .imemRespValid(imemRespValid),
        .imemRespData(imemRespData), .instrD(instrD), .pcD(pcD),
        .pcPlus4D(pcPlus4D), .validD(validD)
    );

    fetch_stage_ctrl #(.RESETPC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .stallF(w_stallF), .stallD(w_stallD), .flushD(w_flushD),
        .takeBranchE(w_takeBranchE), .branchTargetE(w_branchTargetE),
        .imemReqValid(w_imemReqValid), .imemReqReady(w_imemReqReady),
        .imemReqAddress(w_imemReqAddress), .imemRespValid(w_imemRespValid),
        .imemRespData(w_imemRespData), .instrD(w_instrD), .pcD(w_pcD),
        .pcPlus4D(w_pcPlus4D), .validD(w_validD)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        sf, sd, fd, tb;
        logic [31:0] tgt;
        logic        rdy, rsv;
        logic [31:0] rdata;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_vd;
        logic [31:0] e_pcd;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic sf, input logic sd, input logic fd, input logic tb,
                                input logic [31:0] tgt, input logic rdy, input logic rsv,
                                input logic [31:0] rdata, input logic e_rv, input logic [31:0] e_addr,
                                input logic e_vd, input logic [31:0] e_pcd, input logic [31:0] e_instr);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fd = fd; v.tb = tb; v.tgt = tgt;
        v.rdy = rdy; v.rsv = rsv; v.rdata = rdata;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_vd = e_vd; v.e_pcd = e_pcd; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare the main instance's outputs; pc fields only matter while validD.
    task automatic chk_main(input string tag, input logic e_rv, input logic [31:0] e_addr,
                            input logic e_vd, input logic [31:0] e_pcd, input logic [31:0] e_instr);
        chk({tag, " reqValid"}, 32'(imemReqValid), 32'(e_rv));
        chk({tag, " reqAddr"},  imemReqAddress, e_addr);
        chk({tag, " validD"},   32'(validD), 32'(e_vd));
        chk({tag, " instrD"},   instrD, e_instr);
        if (e_vd) begin
            chk({tag, " pcD"},      pcD, e_pcd);
            chk({tag, " pcPlus4D"}, pcPlus4D, e_pcd + 32'd4);
        end
    endtask

    initial begin
        // Cycle-by-cycle vectors after reset release:
        //        sf  sd  fd  tb  target        rdy rsv data          | rv  addr          vD  pcD           instrD
        vecs[0]  = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0);
        vecs[1]  = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         1, 32'h0,   0, 32'h0,   32'h0);
        vecs[2]  = mk(0,0,0,0, 32'h0,   0,1, 32'hA000_0001, 0, 32'h0,   0, 32'h0,   32'h0);
        vecs[3]  = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         1, 32'h4,   1, 32'h0,   32'hA000_0001);
        vecs[4]  = mk(0,0,0,0, 32'h0,   0,1, 32'hA000_0002, 0, 32'h4,   0, 32'h0,   32'h0);
        vecs[5]  = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         1, 32'h8,   1, 32'h4,   32'hA000_0002);
        vecs[6]  = mk(0,0,0,0, 32'h0,   0,1, 32'hA000_0003, 0, 32'h8,   0, 32'h0,   32'h0);
        // three stall cycles; response parked, IF/ID frozen, late data ignored in HOLD
        vecs[7]  = mk(1,1,0,0, 32'h0,   1,0, 32'h0,         1, 32'hC,   1, 32'h8,   32'hA000_0003);
        vecs[8]  = mk(1,1,0,0, 32'h0,   0,1, 32'hA000_0004, 0, 32'hC,   1, 32'h8,   32'hA000_0003);
        vecs[9]  = mk(1,1,0,0, 32'h0,   0,1, 32'hDEAD_0000, 0, 32'hC,   1, 32'h8,   32'hA000_0003);
        vecs[10] = mk(0,0,0,0, 32'h0,   0,0, 32'h0,         0, 32'hC,   1, 32'h8,   32'hA000_0003);
        vecs[11] = mk(0,0,0,0, 32'h0,   0,0, 32'h0,         1, 32'h10,  1, 32'hC,   32'hA000_0004);
        vecs[12] = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         1, 32'h10,  0, 32'h0,   32'h0);
        // redirect in WAIT (unaligned target), stale response dropped
        vecs[13] = mk(0,0,0,1, 32'h103, 0,0, 32'h0,         0, 32'h10,  0, 32'h0,   32'h0);
        vecs[14] = mk(0,0,0,0, 32'h0,   0,1, 32'hBAD0_0001, 0, 32'h100, 0, 32'h0,   32'h0);
        vecs[15] = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         1, 32'h100, 0, 32'h0,   32'h0);
        vecs[16] = mk(0,0,0,0, 32'h0,   0,1, 32'hB000_0100, 0, 32'h100, 0, 32'h0,   32'h0);
        // flush together with stall
        vecs[17] = mk(0,1,1,0, 32'h0,   1,0, 32'h0,         1, 32'h104, 1, 32'h100, 32'hB000_0100);
        // redirect in WAIT with response in the same cycle
        vecs[18] = mk(0,0,0,1, 32'h200, 0,1, 32'hBAD0_0002, 0, 32'h104, 0, 32'h0,   32'h0);
        // redirect in REQ without acceptance, then with acceptance
        vecs[19] = mk(0,0,0,1, 32'h301, 0,0, 32'h0,         1, 32'h200, 0, 32'h0,   32'h0);
        vecs[20] = mk(0,0,0,1, 32'h400, 1,0, 32'h0,         1, 32'h300, 0, 32'h0,   32'h0);
        vecs[21] = mk(0,0,0,0, 32'h0,   0,0, 32'h0,         0, 32'h400, 0, 32'h0,   32'h0);
        vecs[22] = mk(0,0,0,0, 32'h0,   0,1, 32'hBAD0_0003, 0, 32'h400, 0, 32'h0,   32'h0);
        vecs[23] = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         1, 32'h400, 0, 32'h0,   32'h0);
        vecs[24] = mk(0,0,0,0, 32'h0,   0,1, 32'hC000_0400, 0, 32'h400, 0, 32'h0,   32'h0);
        vecs[25] = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         1, 32'h404, 1, 32'h400, 32'hC000_0400);
        // stallF alone parks the response; redirect then discards the buffer
        vecs[26] = mk(1,0,0,0, 32'h0,   0,1, 32'hD000_0404, 0, 32'h404, 0, 32'h0,   32'h0);
        vecs[27] = mk(1,0,0,1, 32'h500, 0,0, 32'h0,         0, 32'h404, 0, 32'h0,   32'h0);
        vecs[28] = mk(0,0,0,0, 32'h0,   1,0, 32'h0,         1, 32'h500, 0, 32'h0,   32'h0);
        vecs[29] = mk(0,0,0,0, 32'h0,   0,1, 32'hE000_0500, 0, 32'h500, 0, 32'h0,   32'h0);
        vecs[30] = mk(0,1,0,0, 32'h0,   1,0, 32'h0,         1, 32'h504, 1, 32'h500, 32'hE000_0500);

        rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; takeBranchE = 1'b0;
        branchTargetE = 32'h0; imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = 32'h0;
        w_rst_n = 1'b0; w_stallF = 1'b0; w_stallD = 1'b0; w_flushD = 1'b0; w_takeBranchE = 1'b0;
        w_branchTargetE = 32'h0; w_imemReqReady = 1'b0; w_imemRespValid = 1'b0; w_imemRespData = 32'h0;

        // Reset state, sampled while rst_n is still low.
        @(negedge clk);
        @(negedge clk);
        chk_main("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("reset pcD", pcD, 32'h0);
        chk("reset pcPlus4D", pcPlus4D, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            chk_main($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_vd,
                     vecs[i].e_pcd, vecs[i].e_instr);
            stallF        = vecs[i].sf;
            stallD        = vecs[i].sd;
            flushD        = vecs[i].fd;
            takeBranchE   = vecs[i].tb;
            branchTargetE = vecs[i].tgt;
            imemReqReady  = vecs[i].rdy;
            imemRespValid = vecs[i].rsv;
            imemRespData  = vecs[i].rdata;
        end

        // Reset asserted in WAIT with IF/ID holding a valid instruction.
        @(negedge clk);
        chk_main("pre_reset", 1'b0, 32'h504, 1'b1, 32'h500, 32'hE000_0500);
        stallD = 1'b0; imemReqReady = 1'b0; imemRespValid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_main("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("async_reset pcD", pcD, 32'h0);
        chk("async_reset pcPlus4D", pcPlus4D, 32'h0);
        // Late response for the abandoned request arrives around release.
        imemReqReady = 1'b1; imemRespValid = 1'b1; imemRespData = 32'hBAD0_0004;
        @(negedge clk);
        chk("in_reset reqValid", 32'(imemReqValid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_main("restart1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        imemRespValid = 1'b0;
        @(negedge clk);
        chk_main("restart2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        imemRespValid = 1'b1; imemRespData = 32'hF000_0000;
        @(negedge clk);
        chk_main("restart3", 1'b1, 32'h4, 1'b1, 32'h0, 32'hF000_0000);
        imemRespValid = 1'b0; imemReqReady = 1'b0;

        // PC wrap from RESETPC = 0xFFFFFFFC.
        chk("wrap reset reqValid", 32'(w_imemReqValid), 32'h0);
        chk("wrap reset reqAddr", w_imemReqAddress, 32'hFFFF_FFFC);
        w_rst_n = 1'b1; w_imemReqReady = 1'b1;
        @(negedge clk);
        chk("wrap req1 reqValid", 32'(w_imemReqValid), 32'h1);
        chk("wrap req1 reqAddr", w_imemReqAddress, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap wait reqValid", 32'(w_imemReqValid), 32'h0);
        w_imemRespValid = 1'b1; w_imemRespData = 32'h1234_5678;
        @(negedge clk);
        w_imemRespValid = 1'b0;
        chk("wrap req2 reqValid", 32'(w_imemReqValid), 32'h1);
        chk("wrap req2 reqAddr", w_imemReqAddress, 32'h0000_0000);
        chk("wrap validD", 32'(w_validD), 32'h1);
        chk("wrap pcD", w_pcD, 32'hFFFF_FFFC);
        chk("wrap pcPlus4D", w_pcPlus4D, 32'h0000_0000);
        chk("wrap instrD", w_instrD, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_stage_ctrl

// File: doc/fetch_stage_ctrl.md
FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

Interface
REQ-001 Parameter PCWIDTH, default 32: width of every program-counter value.
REQ-002 Parameter INSTRWIDTH, default 32: instruction width.
REQ-003 Parameter RESETPC, default 0: fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 stallF  input  1  hold PC; from hazards unit.
REQ-007 stallD  input  1  hold IF/ID register; from hazards unit.
REQ-008 flushD  input  1  invalidate IF/ID register.
REQ-009 takeBranchE  input  1  redirect fetch this cycle.
REQ-010 branchTargetE  input  PCWIDTH  redirect address.
REQ-011 imemReqValid  output  1  instruction-memory request valid.
REQ-012 imemReqReady  input  1  memory accepts request.
REQ-013 imemReqAddress  output  PCWIDTH  request address.
REQ-014 imemRespValid  input  1  response data valid.
REQ-015 imemRespData  input  INSTRWIDTH  response instruction.
REQ-016 instrD, pcD, pcPlus4D  output  INSTRWIDTH/PCWIDTH/PCWIDTH  IF/ID register contents.
REQ-017 validD  output  1  IF/ID holds a real instruction.

Function
REQ-018 SHALL keep at most one request outstanding; states REQ, WAIT, DISCARD, HOLD.
REQ-019 REQ: imemReqValid=1, imemReqAddress=pcF; on valid&&ready go WAIT.
REQ-020 WAIT: on imemRespValid with stallD=0, load instrD/pcD=pcF/pcPlus4D=pcF+4/validD=1 next edge, pcF<=pcF+4, go REQ (one-cycle turnaround minimum, 2 cycles per instruction with zero-latency memory).
REQ-021 WAIT: on imemRespValid with stallD=1 (or stallF=1), capture into internal buffer, pcF unchanged, go HOLD.
REQ-022 HOLD: first cycle stallD=0 transfers buffer into IF/ID, pcF<=pcF+4, go REQ.
REQ-023 Cycles with stallD=0 and no instruction delivered SHALL load validD=0, instrD=NOP (bubble).
REQ-024 stallD=1 without flushD SHALL hold all IF/ID outputs unchanged.
REQ-025 flushD=1 SHALL load validD=0, instrD=NOP; flushD wins over stallD.
REQ-026 takeBranchE=1: pcF<=branchTargetE with bits [1:0] forced 0; HOLD buffer discarded; redirect wins over stallF.
REQ-027 Redirect in WAIT without response that cycle, or in REQ with request accepted that cycle: go DISCARD.
REQ-028 Redirect in WAIT with response that same cycle: response dropped, go REQ.
REQ-029 Redirect in REQ without acceptance: stay REQ; address changes next cycle (protocol allows address change before acceptance).
REQ-030 DISCARD: imemReqValid=0; next imemRespValid dropped, then REQ at the redirected pcF.
REQ-031 imemRespValid in REQ or HOLD SHALL be ignored.
REQ-032 pcF+4 SHALL wrap modulo 2^PCWIDTH.
REQ-033 imemReqValid SHALL be 0 in WAIT, DISCARD, HOLD.

Reset
REQ-034 rst_n=0 SHALL immediately force pcF=RESETPC, state=REQ, validD=0, instrD=NOP, pcD=0, pcPlus4D=0, buffer empty.
REQ-035 imemReqValid SHALL be 0 while rst_n=0 and 1 from the first cycle after release.
REQ-036 Reset mid-transaction SHALL abandon the outstanding request; late responses after release in REQ are ignored per REQ-031.

Structure
REQ-037 Package fetch_pkg SHALL hold fetch_state_t enum, NOP constant (all zeros), RESETPC default.
REQ-038 IF/ID register SHALL be sub-module ifid_register (load, stall, flush, async reset); FSM and PC stay in fetch_stage_ctrl.

Verification
REQ-039 Reset release, ready=1, 1-cycle response latency -> addresses 0x0,0x4,0x8 requested; validD pulses with pcD 0x0,0x4,0x8.
REQ-040 stallD=stallF=1 for 3 cycles while response arrives -> HOLD; IF/ID unchanged; instruction delivered cycle after stall drops, no request reissued.
REQ-041 takeBranchE=1, target 0x103, during WAIT -> stale response dropped, next request 0x100, validD=0 until it returns.
REQ-042 flushD=1 with stallD=1 -> validD=0, instrD=0 next cycle.
REQ-043 RESETPC=0xFFFFFFFC -> second request address 0x00000000.
REQ-044 rst_n pulsed low during WAIT -> outputs at reset values asynchronously; fetch restarts at RESETPC.
